// File: rtl/macc_pkg.sv
// Shared definitions for the matrix controller/datapath pair: output select
// encoding and a helper to classify select values.
package macc_pkg;

  typedef enum logic [1:0] {
    OSEL_RB0 = 2'b00,
    OSEL_RB1 = 2'b01,
    OSEL_RAM = 2'b11
  } out_sel_t;

  localparam logic [1:0] OSEL_RSVD = 2'b10;

  function automatic logic sel_is_legal(input logic [1:0] sel);
    return (sel != OSEL_RSVD);
  endfunction

endpackage

// File: rtl/matrix_dp_if.sv
// Handshake/data bundle between matrix_ctrl (master) and matrix_dp (slave).
interface matrix_dp_if #(
  parameter int ADDR_MSB = 11,
  parameter int DATA_MSB = 15
);
  logic                     wen_to_ram;
  logic [ADDR_MSB:0]        a;
  logic [DATA_MSB:0]        din;
  logic                     shift_to_dp;
  logic [1:0]               out_sel_to_dp;
  logic [DATA_MSB:0]        dout;
  logic [1:0][DATA_MSB:0]   rb_q;

  modport master (
    output wen_to_ram, a, din, shift_to_dp, out_sel_to_dp,
    input  dout, rb_q
  );

  modport slave (
    input  wen_to_ram, a, din, shift_to_dp, out_sel_to_dp,
    output dout, rb_q
  );
endinterface

// File: rtl/matrix_dp_chk.sv
// Protocol checks on the matrix datapath select input.
module matrix_dp_chk
  import macc_pkg::*;
(
  input logic       CLK,
  input logic       RST,
  input logic [1:0] out_sel
);
  a_sel_legal: assert property (@(posedge CLK) disable iff (RST) sel_is_legal(out_sel))
    else $error("matrix_dp: reserved out_sel_to_dp value %b", out_sel);
endmodule

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with a registered read port. The read register
// holds its value on write cycles; contents are never reset.
module ram_sp #(
  parameter int ADDR_MSB = 11,
  parameter int DATA_MSB = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_MSB:0] a,
  input  logic [DATA_MSB:0] d,
  output logic [DATA_MSB:0] q
);
  localparam int DEPTH = 2 ** (ADDR_MSB + 1);

  logic [DATA_MSB:0] mem [DEPTH];
  logic [DATA_MSB:0] q_d;
  logic [DATA_MSB:0] q_q;

  always_comb begin
    q_d = q_q;
    if (we) begin
      q_d = q_q;
    end else begin
      q_d = mem[a];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Storage is outside the reset domain so a write during reset still lands.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[a] <= d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/matrix_dp.sv
// Matrix storage datapath: single-port RAM, two-entry read buffer and the
// output select mux driven by matrix_ctrl.
module matrix_dp
  import macc_pkg::*;
#(
  parameter int ADDR_MSB = 11,
  parameter int DATA_MSB = 15
) (
  input logic         CLK,
  input logic         RST,
  matrix_dp_if.slave  bus
);
  logic [DATA_MSB:0]      q;
  logic [1:0][DATA_MSB:0] rb_d;
  logic [1:0][DATA_MSB:0] rb_q;
  logic [DATA_MSB:0]      dout_s;

  ram_sp #(
    .ADDR_MSB (ADDR_MSB),
    .DATA_MSB (DATA_MSB)
  ) u_ram (
    .CLK (CLK),
    .RST (RST),
    .we  (bus.wen_to_ram),
    .a   (bus.a),
    .d   (bus.din),
    .q   (q)
  );

  // Shift moves q into rb[1] and the old rb[1] into rb[0].
  always_comb begin
    rb_d = rb_q;
    if (bus.shift_to_dp) begin
      rb_d = {q, rb_q[1]};
    end else begin
      rb_d = rb_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rb_q <= '0;
    end else begin
      rb_q <= rb_d;
    end
  end

  always_comb begin
    dout_s = '0;
    case (bus.out_sel_to_dp)
      OSEL_RB0: dout_s = rb_q[0];
      OSEL_RB1: dout_s = rb_q[1];
      OSEL_RAM: dout_s = q;
      default:  dout_s = '0;
    endcase
  end

  assign bus.dout = dout_s;
  assign bus.rb_q = rb_q;

  matrix_dp_chk u_chk (
    .CLK     (CLK),
    .RST     (RST),
    .out_sel (bus.out_sel_to_dp)
  );
endmodule

// File: tb/tb_matrix_dp.sv
// Bench for matrix_dp: directed vector table for the corner cases, then
// randomized traffic checked against a behavioural model of the storage.
module tb_matrix_dp;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  matrix_dp_if #(.ADDR_MSB(11), .DATA_MSB(15)) bus ();

  matrix_dp #(.ADDR_MSB(11), .DATA_MSB(15)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] mem_m [4096];
  logic [15:0] q_m;
  logic [15:0] rb0_m;
  logic [15:0] rb1_m;

  typedef struct {
    logic        rst;
    logic        wen;
    logic [11:0] a;
    logic [15:0] din;
    logic        sh;
    logic [1:0]  sel;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [28];
  logic [11:0] pool [16];

  task automatic apply(input logic rst, input logic wen, input logic [11:0] a,
                       input logic [15:0] din, input logic sh, input logic [1:0] sel);
    RST = rst;
    bus.wen_to_ram = wen;
    bus.a = a;
    bus.din = din;
    bus.shift_to_dp = sh;
    bus.out_sel_to_dp = sel;
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    @(posedge CLK);
    if (RST) begin
      q_m = 16'h0000;
      rb0_m = 16'h0000;
      rb1_m = 16'h0000;
    end else begin
      if (bus.shift_to_dp) begin
        rb0_m = rb1_m;
        rb1_m = q_m;
      end
      if (!bus.wen_to_ram) q_m = mem_m[bus.a];
    end
    if (bus.wen_to_ram) mem_m[bus.a] = bus.din;
    #1;
  endtask

  function automatic logic [15:0] exp_dout(input logic [1:0] sel);
    if (sel == 2'b00) return rb0_m;
    else if (sel == 2'b01) return rb1_m;
    else if (sel == 2'b11) return q_m;
    else return 16'h0000;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 12'd5,  16'hABCD, 1'b0, 2'b11, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 12'd5,  16'h0000, 1'b0, 2'b11, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 12'd5,  16'h0000, 1'b0, 2'b11, 16'hABCD};
    tbl[3]  = '{1'b0, 1'b1, 12'd0,  16'h1111, 1'b0, 2'b00, 16'h0000};
    tbl[4]  = '{1'b0, 1'b1, 12'd1,  16'h2222, 1'b0, 2'b01, 16'h0000};
    tbl[5]  = '{1'b0, 1'b0, 12'd0,  16'h0000, 1'b0, 2'b11, 16'hABCD};
    tbl[6]  = '{1'b0, 1'b0, 12'd1,  16'h0000, 1'b1, 2'b11, 16'h1111};
    tbl[7]  = '{1'b0, 1'b0, 12'd1,  16'h0000, 1'b1, 2'b01, 16'h1111};
    tbl[8]  = '{1'b0, 1'b0, 12'd1,  16'h0000, 1'b0, 2'b00, 16'h1111};
    tbl[9]  = '{1'b0, 1'b0, 12'd1,  16'h0000, 1'b0, 2'b01, 16'h2222};
    tbl[10] = '{1'b1, 1'b0, 12'd1,  16'h0000, 1'b0, 2'b11, 16'h2222};
    tbl[11] = '{1'b0, 1'b0, 12'd0,  16'h0000, 1'b0, 2'b00, 16'h0000};
    tbl[12] = '{1'b0, 1'b0, 12'd0,  16'h0000, 1'b0, 2'b01, 16'h0000};
    tbl[13] = '{1'b0, 1'b0, 12'd0,  16'h0000, 1'b0, 2'b11, 16'h1111};
    tbl[14] = '{1'b0, 1'b1, 12'd3,  16'h3333, 1'b0, 2'b11, 16'h1111};
    tbl[15] = '{1'b0, 1'b0, 12'd3,  16'h0000, 1'b0, 2'b11, 16'h1111};
    tbl[16] = '{1'b0, 1'b1, 12'd7,  16'h4444, 1'b1, 2'b11, 16'h3333};
    tbl[17] = '{1'b0, 1'b0, 12'd7,  16'h0000, 1'b0, 2'b01, 16'h3333};
    tbl[18] = '{1'b0, 1'b0, 12'd7,  16'h0000, 1'b0, 2'b11, 16'h4444};
    tbl[19] = '{1'b0, 1'b1, 12'd9,  16'h5555, 1'b0, 2'b11, 16'h4444};
    tbl[20] = '{1'b0, 1'b0, 12'd9,  16'h0000, 1'b0, 2'b11, 16'h4444};
    tbl[21] = '{1'b0, 1'b0, 12'd9,  16'h0000, 1'b0, 2'b11, 16'h5555};
    tbl[22] = '{1'b1, 1'b0, 12'd9,  16'h0000, 1'b0, 2'b10, 16'h0000};
    tbl[23] = '{1'b0, 1'b0, 12'd9,  16'h0000, 1'b0, 2'b11, 16'h0000};
    tbl[24] = '{1'b0, 1'b0, 12'd9,  16'h0000, 1'b0, 2'b11, 16'h5555};
    tbl[25] = '{1'b1, 1'b1, 12'd12, 16'h6666, 1'b1, 2'b11, 16'h5555};
    tbl[26] = '{1'b0, 1'b0, 12'd12, 16'h0000, 1'b0, 2'b01, 16'h0000};
    tbl[27] = '{1'b0, 1'b0, 12'd12, 16'h0000, 1'b0, 2'b11, 16'h6666};

    q_m = 16'h0000;
    rb0_m = 16'h0000;
    rb1_m = 16'h0000;

    // Reset: every legal select shows zero.
    apply(1'b1, 1'b0, 12'd0, 16'h0000, 1'b0, 2'b00);
    tick();
    tick();
    for (int s = 0; s < 4; s++) begin
      if (s != 2) begin
        bus.out_sel_to_dp = 2'(s);
        #1;
        check16($sformatf("reset_dout_sel%0d", s), bus.dout, 16'h0000);
      end
    end

    // Directed vectors: dout is checked against the state before each edge.
    for (int i = 0; i < 28; i++) begin
      apply(tbl[i].rst, tbl[i].wen, tbl[i].a, tbl[i].din, tbl[i].sh, tbl[i].sel);
      #1;
      check16($sformatf("vec%0d_dout", i), bus.dout, tbl[i].exp);
      if (i == 8) begin
        check16("two_shift_rb0", bus.rb_q[0], 16'h1111);
        check16("two_shift_rb1", bus.rb_q[1], 16'h2222);
      end
      if (i == 17) check16("shift_wr_rb1", bus.rb_q[1], 16'h3333);
      if (i == 11) begin
        check16("rst_mid_rb0", bus.rb_q[0], 16'h0000);
        check16("rst_mid_rb1", bus.rb_q[1], 16'h0000);
      end
      tick();
    end

    // Randomized phase: preload a pool of addresses spanning the full width.
    for (int k = 0; k < 16; k++) pool[k] = 12'(k);
    pool[13] = 12'hFFF;
    pool[14] = 12'h800;
    pool[15] = 12'h7FF;
    apply(1'b1, 1'b0, 12'd0, 16'h0000, 1'b0, 2'b11);
    tick();
    for (int k = 0; k < 16; k++) begin
      apply(1'b0, 1'b1, pool[k], 16'($urandom), 1'b0, 2'b11);
      tick();
    end
    for (int n = 0; n < 400; n++) begin
      logic        r_rst;
      logic [1:0]  r_sel;
      int          pick;
      r_rst = ($urandom_range(0, 39) == 0);
      pick = $urandom_range(0, 2);
      r_sel = (pick == 0) ? 2'b00 : ((pick == 1) ? 2'b01 : 2'b11);
      if (r_rst && $urandom_range(0, 1) == 1) r_sel = 2'b10;
      apply(r_rst, ($urandom_range(0, 3) == 0), pool[$urandom_range(0, 15)],
            16'($urandom), 1'($urandom_range(0, 1)), r_sel);
      #1;
      check16("rand_dout", bus.dout, exp_dout(r_sel));
      check16("rand_rb0", bus.rb_q[0], rb0_m);
      check16("rand_rb1", bus.rb_q[1], rb1_m);
      tick();
    end

    // Final sweep: read back every pool entry through OSEL_RAM.
    for (int k = 0; k < 16; k++) begin
      apply(1'b0, 1'b0, pool[k], 16'h0000, 1'b0, 2'b11);
      tick();
      #1;
      check16("sweep_q", bus.dout, mem_m[pool[k]]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_dp.md
# matrix_dp

Matrix storage datapath that sits directly downstream of `matrix_ctrl` and consumes its outputs (`wen_to_ram`, `a`, `shift_to_dp`, `out_sel_to_dp`). It holds one matrix in a single-port synchronous RAM, registers the RAM read data, and keeps a two-entry read buffer so software reads hide RAM latency. It presents the selected word on `dout` in the same cycle `out_sel_to_dp` selects it.

## Interface
- `ADDR_MSB`, default 11: MSB of the RAM word address. Depth is 2^(ADDR_MSB+1).
- `DATA_MSB`, default 15: MSB of the data word.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; one clock, synchronous, active-high. Resets buffer and register state only; RAM contents are not reset.
- `wen_to_ram`  in  1  write `din` to `mem[a]` this cycle.
- `a`  in  ADDR_MSB+1  RAM address, used for both write and read.
- `din`  in  DATA_MSB+1  write data.
- `shift_to_dp`  in  1  shift the RAM read register into the read buffer.
- `out_sel_to_dp`  in  2  output source select.
- `dout`  out  DATA_MSB+1  selected read data, combinational from registers.
- `rb_q`  out  2×(DATA_MSB+1)  read-buffer contents, exported for debug and verification.

## Operation
- **State.** `mem[]`, RAM read register `q`, and read buffer `rb[1]`, `rb[0]`.
- **Write.** `wen_to_ram=1` sets `mem[a] <= din`. `q` holds on a write cycle.
- **Read.** `wen_to_ram=0` sets `q <= mem[a]` every cycle. There is no separate read enable. A read of an address written on the previous edge returns the new data.
- **Shift.** `shift_to_dp=1` sets `rb[1] <= q` and `rb[0] <= rb[1]`, both using the pre-edge values. Otherwise `rb` holds.
- **Shift with write.** `shift_to_dp` together with `wen_to_ram` is legal: the shift uses the held `q` and the write proceeds.
- **Output mux (`out_sel_to_dp`).**
  - `00` (OSEL_RB0): `dout = rb[0]`
  - `01` (OSEL_RB1): `dout = rb[1]`
  - `11` (OSEL_RAM): `dout = q`
  - `10` is reserved: `dout = 0`, and the assertion fires.
- **Datapath only.** The block holds no valid bits. Validity is owned by `matrix_ctrl`, and this block never blocks or stalls.
- **Widths.** Data is never resized. `a` indexes `mem` directly, with no wrap logic.

## Timing
- **Reset values.** `q`, `rb[1]` and `rb[0]` reset to 0. Hence `dout = 0` for every select while or after reset, until new data arrives.
- **Write latency.** Address and data presented at edge t are stored at edge t. They are readable into `q` at edge t+1.
- **Read latency.** `a` presented with `wen_to_ram=0` before edge t gives `q = mem[a]` from t, visible on `dout` (OSEL_RAM) in cycle t+1.
- **Shift latency.** A shift at edge t makes `q` visible in `rb[1]` from t. It reaches `rb[0]` after a second shift.
- **Reset with simultaneous shift or write.**
  - Reset wins over shift: `q`, `rb[1]` and `rb[0]` all go to 0.
  - A write in the same cycle as reset still updates `mem`.
- **Reset mid-operation.** RAM contents are retained across reset. Buffered data is lost.

## Structure
- **Shared package `macc_pkg`:**
  - `out_sel_t` enum: OSEL_RB0=2'b00, OSEL_RB1=2'b01, OSEL_RAM=2'b11.
  - Used by both `matrix_ctrl` and `matrix_dp`.
- **Sub-module `ram_sp`:** single-port synchronous RAM with parameters `ADDR_MSB`/`DATA_MSB` and ports `CLK`, `we`, `a`, `d`, `q`. It owns `mem` and `q`, including the hold-on-write rule. `matrix_dp` instantiates it and adds the read buffer and output mux.
- **Assertions:** `out_sel_to_dp != 2'b10` whenever not in reset.

## Test plan
- **Write then read:** write 0xABCD to a=5, then drive a=5 with `wen_to_ram=0` and OSEL_RAM -> `dout=0xABCD` one cycle later.
- **Two-shift pipeline:** write 0x1111 to a=0 and 0x2222 to a=1, read a=0 then shift, read a=1 then shift -> `rb[0]=0x1111`, `rb[1]=0x2222`. OSEL_RB0/OSEL_RB1 show each value.
- **Shift with write:** hold `q=0x3333`, then in one cycle write 0x4444 to a=7 and shift -> `rb[1]=0x3333`, `mem[7]=0x4444`, `q` unchanged.
- **Read-after-write:** write 0x5555 to a=9, next cycle read a=9 -> `q=0x5555`, not stale data.
- **Reset mid-operation:** with `rb` holding 0x1111/0x2222, assert `RST` for one cycle -> `dout=0` for all legal selects. A read of a=0 afterwards still returns 0x1111.
- **Reserved select:** drive `out_sel_to_dp=10` -> `dout=0` and the assertion fires.
